// File: rtl/ram_dp_pipe_pkg.sv
// ram_pkg: shared types and helpers for the ram_dp_pipe RAM.
//   rw_mode_e : same-address read/write collision behaviour
//   state_e   : post-reset clear state machine states
//   be_width(), depth() : derived sizes from the RAM parameters
package ram_pkg;

  typedef enum logic {
    RW_READ_FIRST  = 1'b0,
    RW_WRITE_FIRST = 1'b1
  } rw_mode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 4;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_dp_pipe_rd_pipe.sv
// ram_rd_pipe: read-data delay line placed after the array read stage.
//   clk, rst_n : clock, asynchronous active-low clear of valids and data
//   i_vld/i_data : read result from the array read stage
//   o_vld/o_data : result delayed by STAGES edges; o_data holds while o_vld is low
module ram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [STAGES-1:0]     r_vld;
  logic [DATA_WIDTH-1:0] r_data [STAGES];

  // Data registers only load alongside a valid, so the last stage holds the
  // most recent read result between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_data[0] <= i_data;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign o_vld  = r_vld[STAGES-1];
  assign o_data = r_data[STAGES-1];

endmodule

// File: rtl/ram_dp_pipe.sv
// ram_dp_pipe: simple dual-port synchronous RAM (one write, one read port).
//   clk, rst_n        : clock, asynchronous active-low reset
//   we, wr_be         : write enable, per-byte lane enables
//   wr_addr, wr_din   : write address and data
//   re, rd_addr       : read enable and address
//   rd_dout, rd_valid : read data, valid RD_LATENCY edges after the read
//   init_busy         : post-reset clear in progress; requests ignored
//   req_drop          : one-cycle pulse after a request ignored during clear
module ram_dp_pipe
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RW_MODE        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [DATA_WIDTH/8-1:0]    wr_be,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_din,
  input  logic                       re,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_dout,
  output logic                       rd_valid,
  output logic                       init_busy,
  output logic                       req_drop
);

  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);
  localparam int unsigned DEPTH    = depth(ADDR_WIDTH);
  localparam rw_mode_e    MODE     = (RW_MODE != 0) ? RW_WRITE_FIRST : RW_READ_FIRST;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_drop;
  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_busy;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_busy    = (r_state == ST_CLEAR);
  assign w_wr_fire = we && !w_busy && (|wr_be);
  assign w_rd_fire = re && !w_busy;
  assign w_collide = (MODE == RW_WRITE_FIRST) && w_wr_fire && (rd_addr == wr_addr);

  // Write-first collisions forward the merged word; read-first relies on the
  // array update landing after this edge's read.
  always_comb begin
    w_rd_word = r_mem[rd_addr];
    if (w_collide) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          w_rd_word[8*i +: 8] = wr_din[8*i +: 8];
        end
      end
    end
  end

  // The array has no reset; the clear FSM owns the write port while busy.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_cnt     <= '0;
      r_drop    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_drop   <= w_busy && (we || re);
      r_rd_vld <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= w_rd_word;
      end
      if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '1) begin
          r_state <= ST_READY;
        end
      end
    end
  end

  assign init_busy = w_busy;
  assign req_drop  = r_drop;

  generate
    if (RD_LATENCY > RD_LATENCY_MIN) begin : g_pipe
      ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
      ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (r_rd_vld),
        .i_data (r_rd_data),
        .o_vld  (rd_valid),
        .o_data (rd_dout)
      );
    end else begin : g_direct
      assign rd_valid = r_rd_vld;
      assign rd_dout  = r_rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Directed bench for ram_dp_pipe: two instances share stimulus,
// one read-first with latency 1, one write-first with latency 3.
module tb_ram_dp_pipe;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wr_be;
  logic [7:0]  wr_addr;
  logic [31:0] wr_din;
  logic        re;
  logic [7:0]  rd_addr;

  logic [31:0] dout0, dout1;
  logic        vld0, vld1, busy0, busy1, drop0, drop1;

  int unsigned total;
  int unsigned bad;

  // expected-output model: dut0 latency 1, dut1 latency 3
  logic [2:0]  m1v;
  logic [31:0] m1d [3];
  logic [31:0] last0, last1;

  ram_dp_pipe #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32),
    .RD_LATENCY     (1),
    .RW_MODE        (0),
    .CLEAR_ON_RESET (1)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wr_be     (wr_be),
    .wr_addr   (wr_addr),
    .wr_din    (wr_din),
    .re        (re),
    .rd_addr   (rd_addr),
    .rd_dout   (dout0),
    .rd_valid  (vld0),
    .init_busy (busy0),
    .req_drop  (drop0)
  );

  ram_dp_pipe #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32),
    .RD_LATENCY     (3),
    .RW_MODE        (1),
    .CLEAR_ON_RESET (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wr_be     (wr_be),
    .wr_addr   (wr_addr),
    .wr_din    (wr_din),
    .re        (re),
    .rd_addr   (rd_addr),
    .rd_dout   (dout1),
    .rd_valid  (vld1),
    .init_busy (busy1),
    .req_drop  (drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1v   = '0;
    m1d[0] = '0; m1d[1] = '0; m1d[2] = '0;
    last0 = '0;
    last1 = '0;
  endtask

  // One clock: v = a read is accepted at this edge; e0/e1 = word each DUT returns.
  task automatic step(input logic v, input logic [31:0] e0, input logic [31:0] e1);
    @(posedge clk); #1;
    m1v[2] = m1v[1]; m1d[2] = m1d[1];
    m1v[1] = m1v[0]; m1d[1] = m1d[0];
    m1v[0] = v;      m1d[0] = e1;
    if (v)      last0 = e0;
    if (m1v[2]) last1 = m1d[2];
    chk("vld0",  {31'd0, vld0}, {31'd0, v});
    chk("dout0", dout0, last0);
    chk("vld1",  {31'd0, vld1}, {31'd0, m1v[2]});
    chk("dout1", dout1, last1);
  endtask

  task automatic drain();
    re = 1'b0;
    we = 1'b0;
    repeat (3) step(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int unsigned n;
    logic        seen;
    logic [31:0] d;
    total = 0;
    bad   = 0;
    model_reset();
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    wr_be = '0; wr_addr = '0; wr_din = '0; rd_addr = '0;

    // reset state
    #1;
    chk("rst_vld0",  {31'd0, vld0},  32'd0);
    chk("rst_dout0", dout0,          32'd0);
    chk("rst_drop0", {31'd0, drop0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd1);
    chk("rst_vld1",  {31'd0, vld1},  32'd0);
    chk("rst_dout1", dout1,          32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // release reset; write 0x40 during clear must be dropped
    rst_n = 1'b1;
    we = 1'b1; wr_addr = 8'h40; wr_din = 32'hFFFF_FFFF; wr_be = 4'hF;
    @(posedge clk); #1; n = 1;
    chk("drop_pulse0", {31'd0, drop0}, 32'd1);
    chk("drop_pulse1", {31'd0, drop1}, 32'd1);
    we = 1'b0;
    @(posedge clk); #1; n = 2;
    chk("drop_end0", {31'd0, drop0}, 32'd0);
    while (busy0 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("clear_edges", n, 32'd256);
    chk("busy1_done",  {31'd0, busy1}, 32'd0);

    // cleared contents
    re = 1'b1;
    rd_addr = 8'h00; step(1'b1, 32'h0, 32'h0);
    rd_addr = 8'h7F; step(1'b1, 32'h0, 32'h0);
    rd_addr = 8'hFF; step(1'b1, 32'h0, 32'h0);
    rd_addr = 8'h40; step(1'b1, 32'h0, 32'h0);
    drain();

    // byte merge
    we = 1'b1; wr_addr = 8'h05; wr_din = 32'hDEAD_BEEF; wr_be = 4'hF;
    step(1'b0, 32'h0, 32'h0);
    wr_din = 32'h0000_1200; wr_be = 4'b0010;
    step(1'b0, 32'h0, 32'h0);
    we = 1'b0; re = 1'b1; rd_addr = 8'h05;
    step(1'b1, 32'hDEAD_12EF, 32'hDEAD_12EF);
    re = 1'b0; we = 1'b1; wr_din = 32'h1234_5678; wr_be = 4'h0;
    step(1'b0, 32'h0, 32'h0);
    chk("be0_nodrop", {31'd0, drop0}, 32'd0);
    we = 1'b0; re = 1'b1;
    step(1'b1, 32'hDEAD_12EF, 32'hDEAD_12EF);
    drain();

    // collision
    we = 1'b1; wr_addr = 8'h20; wr_din = 32'h1111_1111; wr_be = 4'hF;
    step(1'b0, 32'h0, 32'h0);
    wr_din = 32'hAAAA_AAAA; wr_be = 4'b0011; re = 1'b1; rd_addr = 8'h20;
    step(1'b1, 32'h1111_1111, 32'h1111_AAAA);
    we = 1'b0;
    step(1'b1, 32'h1111_AAAA, 32'h1111_AAAA);
    // independent addresses on the same edge
    we = 1'b1; wr_addr = 8'h21; wr_din = 32'h2222_2222; wr_be = 4'hF;
    step(1'b1, 32'h1111_AAAA, 32'h1111_AAAA);
    we = 1'b0; rd_addr = 8'h21;
    step(1'b1, 32'h2222_2222, 32'h2222_2222);
    drain();

    // streaming
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wr_be = 4'hF; wr_addr = 8'(i); wr_din = 32'(i) * 32'h0101_0101;
      step(1'b0, 32'h0, 32'h0);
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 8'(i);
      d = 32'(i) * 32'h0101_0101;
      step(1'b1, d, d);
    end
    drain();

    // reset mid-stream
    re = 1'b1;
    rd_addr = 8'h00; step(1'b1, 32'h0, 32'h0);
    rd_addr = 8'h01; step(1'b1, 32'h0101_0101, 32'h0101_0101);
    rd_addr = 8'h02;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_vld0",  {31'd0, vld0},  32'd0);
    chk("mid_vld1",  {31'd0, vld1},  32'd0);
    chk("mid_dout1", dout1,          32'd0);
    chk("mid_busy0", {31'd0, busy0}, 32'd1);
    chk("mid_busy1", {31'd0, busy1}, 32'd1);
    @(posedge clk); #1;
    chk("mid_vld1_held", {31'd0, vld1}, 32'd0);
    rst_n = 1'b1;
    rd_addr = 8'h03;
    model_reset();
    @(posedge clk); #1; n = 1;
    chk("mid_drop0", {31'd0, drop0}, 32'd1);
    seen = vld0 | vld1;
    re = 1'b0;
    while (busy0 && n < 1000) begin
      @(posedge clk); #1; n++;
      seen = seen | vld0 | vld1;
    end
    chk("reclear_edges",  n, 32'd256);
    chk("reclear_novld", {31'd0, seen}, 32'd0);

    // clear restarted from 0 and wiped earlier data
    re = 1'b1;
    rd_addr = 8'h01; step(1'b1, 32'h0, 32'h0);
    rd_addr = 8'h05; step(1'b1, 32'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
